// File: rtl/triangle_pkg.sv
// -----------------------------------------------------------------------------
// triangle_pkg
//   Types shared by the triangle-wave source and its receive-side monitor.
//   dir_t           : stream direction (1 = counting up, 0 = counting down).
//                     The encoding is fixed because both ends exchange it.
//   monitor_state_t : monitor FSM state.
// -----------------------------------------------------------------------------
package triangle_pkg;

   typedef enum logic {
      COUNTING_DOWN = 1'b0,
      COUNTING_UP   = 1'b1
   } dir_t;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      ACQUIRE    = 2'd1,
      TRACK_UP   = 2'd2,
      TRACK_DOWN = 2'd3
   } monitor_state_t;

   // Width of the optional error-event counter.
   localparam int ERR_COUNT_W = 16;

endpackage

// File: rtl/triangle_step_check.sv
// -----------------------------------------------------------------------------
// triangle_step_check
//   Combinational step classifier for one incoming sample against the
//   previously accepted sample.
//   Ports:
//     prev         in  N  last accepted sample
//     in           in  N  candidate sample
//     dir          in  1  tracked direction (dir_t)
//     is_up_step   out 1  in == prev+1 without wrapping past the top
//     is_down_step out 1  in == prev-1 without wrapping below zero
//     at_max       out 1  in is the top of the range (2^N-1)
//     at_zero      out 1  in is the bottom of the range
// -----------------------------------------------------------------------------
module triangle_step_check
   import triangle_pkg::*;
#(
   parameter int N = 8
) (
   input  logic [N-1:0] prev,
   input  logic [N-1:0] in,
   input  dir_t         dir,
   output logic         is_up_step,
   output logic         is_down_step,
   output logic         at_max,
   output logic         at_zero
);

   localparam logic [N-1:0] MAX = '1;
   localparam logic [N-1:0] ONE = N'(1);

   // The prev guards make max->0 and 0->max wraps illegal even though the
   // N-bit add/subtract would otherwise match them.
   assign is_up_step   = (prev != MAX) && (in == prev + ONE);
   assign is_down_step = (prev != '0)  && (in == prev - ONE);
   assign at_max       = (in == MAX);
   assign at_zero      = (in == '0);

   // Legality here is direction-agnostic; the FSM decides which step it
   // accepts, so the shared direction input is only carried through.
   logic unused_dir;
   assign unused_dir = dir;

endmodule

// File: rtl/triangle_monitor.sv
// -----------------------------------------------------------------------------
// triangle_monitor
//   Receive-side checker for a triangle-wave sample stream
//   (0,1,..,2^N-1,2^N-2,..,0,1,..). Consumes one sample per cycle while ena
//   is high, tracks direction, flags peaks/troughs/illegal steps, declares
//   lock after LOCK_STEPS consecutive legal steps, and measures the number
//   of samples between successive troughs once locked.
//
//   Parameters:
//     N          sample width
//     P          period counter width (>= N+2)
//     LOCK_STEPS consecutive legal steps needed for lock (>= 1)
//
//   Ports:
//     clk          in  1  clock, all state on posedge
//     rst          in  1  asynchronous reset, active low
//     ena          in  1  sample valid; full hold when low (pulses clear)
//     in           in  N  sample value
//     dir          out 1  tracked direction (dir_t)
//     locked       out 1  stream verified legal
//     peak         out 1  pulse: top sample accepted while going up
//     trough       out 1  pulse: zero sample accepted while going down
//     error        out 1  pulse: illegal step
//     period       out P  samples between the last two locked troughs
//     period_valid out 1  pulse when period updates
//     err_count    out 16 saturating error-pulse count
//                         (only with TRIANGLE_MONITOR_ERR_COUNT_EN defined)
//
//   All outputs are registered: the response to a sample appears the cycle
//   after the edge that accepted it.
// -----------------------------------------------------------------------------
module triangle_monitor
   import triangle_pkg::*;
#(
   parameter int N          = 8,
   parameter int P          = 10,
   parameter int LOCK_STEPS = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ena,
   input  logic [N-1:0] in,
   output dir_t         dir,
   output logic         locked,
   output logic         peak,
   output logic         trough,
   output logic         error,
   output logic [P-1:0] period,
   output logic         period_valid
`ifdef TRIANGLE_MONITOR_ERR_COUNT_EN
   ,
   output logic [ERR_COUNT_W-1:0] err_count
`endif
);

   localparam int GOOD_W = $clog2(LOCK_STEPS + 1);
   localparam logic [GOOD_W-1:0] GOOD_MAX = GOOD_W'(LOCK_STEPS);
   localparam logic [GOOD_W-1:0] GOOD_ONE = GOOD_W'(1);
   localparam logic [P-1:0]      PER_MAX  = '1;
   localparam logic [P-1:0]      PER_ONE  = P'(1);

   monitor_state_t      state;
   logic [N-1:0]        prev;
   logic [GOOD_W-1:0]   good_cnt;
   logic [P-1:0]        per_cnt;
   logic                armed;      // a locked trough has started a measurement

   logic                is_up_step;
   logic                is_down_step;
   logic                at_max;
   logic                at_zero;

   logic                legal;
   logic                going_up;
   logic                step_err;
   logic                hit_peak;
   logic                hit_trough;
   logic [GOOD_W-1:0]   good_nx;
   logic                lock_nx;
   logic [P-1:0]        per_inc;

   triangle_step_check #(.N(N)) u_step (
      .prev         (prev),
      .in           (in),
      .dir          (dir),
      .is_up_step   (is_up_step),
      .is_down_step (is_down_step),
      .at_max       (at_max),
      .at_zero      (at_zero)
   );

   // Step legality for the current state. In ACQUIRE either direction is
   // accepted and the one taken decides where tracking starts.
   always_comb begin
      legal    = 1'b0;
      going_up = 1'b0;
      case (state)
         ACQUIRE: begin
            legal    = is_up_step | is_down_step;
            going_up = is_up_step;
         end
         TRACK_UP: begin
            legal    = is_up_step;
            going_up = 1'b1;
         end
         TRACK_DOWN: begin
            legal    = is_down_step;
            going_up = 1'b0;
         end
         default: ;
      endcase
   end

   // IDLE only captures the first sample, so it can never be an error.
   assign step_err   = (state != IDLE) && !legal;
   // A turning point reached on the resolving ACQUIRE step is treated like
   // one reached while tracking: the stream can only reverse from there.
   assign hit_peak   = legal &&  going_up && at_max;
   assign hit_trough = legal && !going_up && at_zero;

   assign good_nx = (good_cnt == GOOD_MAX) ? good_cnt : good_cnt + GOOD_ONE;
   // Lock as it will be after this step; a trough on the very step that
   // completes lock already counts as a locked trough.
   assign lock_nx = locked || (good_nx == GOOD_MAX);
   // Shared saturating increment for per_cnt and for period = per_cnt+1.
   assign per_inc = (per_cnt == PER_MAX) ? PER_MAX : per_cnt + PER_ONE;

   // FSM, previous sample, direction and event pulses.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         prev   <= '0;
         dir    <= COUNTING_UP;
         peak   <= 1'b0;
         trough <= 1'b0;
         error  <= 1'b0;
      end else begin
         peak   <= ena && hit_peak;
         trough <= ena && hit_trough;
         error  <= ena && step_err;
         if (ena) begin
            prev <= in;
            if ((state == IDLE) || step_err) begin
               state <= ACQUIRE;
            end else if (hit_peak) begin
               state <= TRACK_DOWN;
               dir   <= COUNTING_DOWN;
            end else if (hit_trough) begin
               state <= TRACK_UP;
               dir   <= COUNTING_UP;
            end else if (going_up) begin
               state <= TRACK_UP;
               dir   <= COUNTING_UP;
            end else begin
               state <= TRACK_DOWN;
               dir   <= COUNTING_DOWN;
            end
         end
      end
   end

   // Lock qualification: consecutive legal steps, saturating.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         good_cnt <= '0;
         locked   <= 1'b0;
      end else if (ena && (state != IDLE)) begin
         if (step_err) begin
            good_cnt <= '0;
            locked   <= 1'b0;
         end else begin
            good_cnt <= good_nx;
            locked   <= lock_nx;
         end
      end
   end

   // Period measurement. The first locked trough arms the counter; each
   // later trough publishes per_cnt+1 (the trough sample itself counts).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         per_cnt      <= '0;
         armed        <= 1'b0;
         period       <= '0;
         period_valid <= 1'b0;
      end else begin
         period_valid <= 1'b0;
         if (ena) begin
            if (step_err) begin
               per_cnt <= '0;
               armed   <= 1'b0;
            end else if (hit_trough && lock_nx) begin
               if (armed) begin
                  period       <= per_inc;
                  period_valid <= 1'b1;
               end
               armed   <= 1'b1;
               per_cnt <= '0;
            end else if (armed) begin
               per_cnt <= per_inc;
            end
         end
      end
   end

`ifdef TRIANGLE_MONITOR_ERR_COUNT_EN
   // Saturating count of error pulses; only reset clears it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_count <= '0;
      end else if (ena && step_err && (err_count != '1)) begin
         err_count <= err_count + ERR_COUNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_triangle_monitor.sv
// -----------------------------------------------------------------------------
// tb_triangle_monitor
//   Self-checking bench for triangle_monitor (N=4, P=6, LOCK_STEPS=4).
//   A behavioural model advanced once per accepted clock edge predicts every
//   output; a negedge process compares the DUT against it each cycle and
//   also evaluates hand-computed expectations requested by the stimulus.
//   Define TRIANGLE_MONITOR_ERR_COUNT_EN to also exercise err_count.
// -----------------------------------------------------------------------------
module tb_triangle_monitor;

   localparam int N    = 4;
   localparam int P    = 6;
   localparam int LK   = 4;
   localparam int MAXV = 15;
   localparam int PMAX = 63;
   localparam int M_NONE = 0, M_ACQ = 1, M_UP = 2, M_DN = 3;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         ena = 1'b0;
   logic [N-1:0] smp = '0;
   logic         dir, locked, peak, trough, error, period_valid;
   logic [P-1:0] period;
`ifdef TRIANGLE_MONITOR_ERR_COUNT_EN
   logic [15:0]  err_count;
`endif

   triangle_monitor #(.N(N), .P(P), .LOCK_STEPS(LK)) dut (
      .clk          (clk),
      .rst          (rst),
      .ena          (ena),
      .in           (smp),
      .dir          (dir),
      .locked       (locked),
      .peak         (peak),
      .trough       (trough),
      .error        (error),
      .period       (period),
      .period_valid (period_valid)
`ifdef TRIANGLE_MONITOR_ERR_COUNT_EN
      ,
      .err_count    (err_count)
`endif
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   int m_mode, m_prev, m_good, m_per, m_period, m_errcnt;
   bit m_dir, m_locked, m_peak, m_trough, m_err, m_pv, m_armed;
   int n_peak, n_trough, n_err, n_pv, s_idx, lock_at;
   int pin_req = 0;
   int n_cmp   = 0;
   int n_fail  = 0;

   task automatic m_reset();
      m_mode = M_NONE; m_prev = 0; m_dir = 1'b1; m_locked = 1'b0; m_good = 0;
      m_peak = 1'b0; m_trough = 1'b0; m_err = 1'b0; m_pv = 1'b0;
      m_period = 0; m_armed = 1'b0; m_per = 0; m_errcnt = 0;
   endtask

   task automatic clear_stats();
      n_peak = 0; n_trough = 0; n_err = 0; n_pv = 0; s_idx = -1; lock_at = -1;
   endtask

   // One clock edge of the ideal monitor, from the stream rules.
   task automatic model_step();
      int s;
      bit up_ok, dn_ok, ok, goes_up;
      if (!rst) begin
         m_reset();
         return;
      end
      m_peak = 1'b0; m_trough = 1'b0; m_err = 1'b0; m_pv = 1'b0;
      if (!ena) return;
      s = int'(smp);
      s_idx++;
      up_ok = (m_prev != MAXV) && (s == m_prev + 1);
      dn_ok = (m_prev != 0)    && (s == m_prev - 1);
      if (m_mode == M_NONE) begin
         m_mode = M_ACQ;
         m_prev = s;
         return;
      end
      case (m_mode)
         M_ACQ:   ok = up_ok || dn_ok;
         M_UP:    ok = up_ok;
         default: ok = dn_ok;
      endcase
      goes_up = (m_mode == M_ACQ) ? up_ok : (m_mode == M_UP);
      m_prev = s;
      if (!ok) begin
         m_err = 1'b1; m_locked = 1'b0; m_good = 0; m_armed = 1'b0; m_per = 0;
         m_mode = M_ACQ; n_err++;
         if (m_errcnt < 65535) m_errcnt++;
         return;
      end
      if (m_good < LK) m_good++;
      if ((m_good == LK) && !m_locked) begin
         m_locked = 1'b1;
         if (lock_at < 0) lock_at = s_idx;
      end
      if (goes_up && s == MAXV) begin
         m_peak = 1'b1; n_peak++; m_dir = 1'b0; m_mode = M_DN;
      end else if (!goes_up && s == 0) begin
         m_trough = 1'b1; n_trough++; m_dir = 1'b1; m_mode = M_UP;
      end else begin
         m_dir = goes_up; m_mode = goes_up ? M_UP : M_DN;
      end
      if (m_trough && m_locked) begin
         if (m_armed) begin
            m_period = (m_per + 1 > PMAX) ? PMAX : m_per + 1;
            m_pv = 1'b1; n_pv++;
         end
         m_armed = 1'b1; m_per = 0;
      end else if (m_armed && m_per < PMAX) begin
         m_per++;
      end
   endtask

   function automatic int wave(input int i);
      int p;
      p = i % 30;
      return (p <= MAXV) ? p : 30 - p;
   endfunction

   // ---------------- compare process ----------------
   task automatic chk(input string nm, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("dir",          int'(dir),          int'(m_dir));
      chk("locked",       int'(locked),       int'(m_locked));
      chk("peak",         int'(peak),         int'(m_peak));
      chk("trough",       int'(trough),       int'(m_trough));
      chk("error",        int'(error),        int'(m_err));
      chk("period",       int'(period),       m_period);
      chk("period_valid", int'(period_valid), int'(m_pv));
`ifdef TRIANGLE_MONITOR_ERR_COUNT_EN
      chk("err_count",    int'(err_count),    m_errcnt);
`endif
      case (pin_req)
         1: begin
            chk("reset_dir",    int'(m_dir), 1);
            chk("reset_period", m_period,    0);
         end
         2: begin
            chk("clean_lock_at",  lock_at,  4);
            chk("clean_peaks",    n_peak,   2);
            chk("clean_troughs",  n_trough, 2);
            chk("clean_pv_count", n_pv,     1);
            chk("clean_errors",   n_err,    0);
            chk("clean_period",   m_period, 30);
         end
         3: begin
            chk("glitch_error",  int'(m_err),    1);
            chk("glitch_unlock", int'(m_locked), 0);
         end
         4: chk("relock_not_yet", int'(m_locked), 0);
         5: chk("relock_done",    int'(m_locked), 1);
         7: begin
            chk("async_rst_locked", int'(locked), 0);
            chk("async_rst_dir",    int'(dir),    1);
            chk("async_rst_period", int'(period), 0);
            chk("async_rst_error",  int'(error),  0);
         end
         8: begin
            chk("post_rst_errors",  n_err,          0);
            chk("post_rst_locked",  int'(m_locked), 1);
            chk("post_rst_lock_at", lock_at,        4);
         end
         9: begin
            chk("mid_desc_dir",   int'(m_dir), 0);
            chk("mid_desc_noerr", n_err,       0);
         end
         10: begin
            chk("mid_desc_trough", int'(m_trough), 1);
            chk("mid_desc_errors", n_err,          0);
         end
         11: chk("wrap_error", int'(m_err), 1);
         12: chk("rand_period_seen", int'(n_pv > 0), 1);
`ifdef TRIANGLE_MONITOR_ERR_COUNT_EN
         13: chk("err_count_3",   m_errcnt, 3);
         14: chk("err_count_sat", m_errcnt, 65535);
`endif
         default: ;
      endcase
   end

   // ---------------- stimulus ----------------
   task automatic send(input int v, input bit e);
      ena = e;
      smp = v[N-1:0];
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic pin(input int id);
      pin_req = id;
      @(negedge clk);
      #1;
      pin_req = 0;
   endtask

   task automatic do_reset();
      ena = 1'b0;
      rst = 1'b0;
      m_reset();
      @(posedge clk);
      @(posedge clk);
      #2;
      rst = 1'b1;
      clear_stats();
   endtask

   initial begin
      int  gpos;
      bit  gup;
      #1;
      do_reset();
      pin(1);

      // Clean wave from reset: 0..15..0..15..0
      for (int i = 0; i <= 60; i++) send(wave(i), 1'b1);
      pin(2);

      // 7 -> 9 glitch while locked going up, then recovery
      for (int v = 1; v <= 7; v++) send(v, 1'b1);
      send(9, 1'b1);
      pin(3);
      send(10, 1'b1); send(11, 1'b1); send(12, 1'b1);
      pin(4);
      send(13, 1'b1);
      pin(5);

      // Same clean wave, one accepted sample in three cycles
      do_reset();
      for (int i = 0; i <= 60; i++) begin
         send(wave(i), 1'b1);
         send(int'($urandom_range(0, MAXV)), 1'b0);
         send(int'($urandom_range(0, MAXV)), 1'b0);
      end
      pin(2);

      // Async reset mid-rise at 9, then clean re-acquisition
      for (int v = 1; v <= 9; v++) send(v, 1'b1);
      #2;
      ena = 1'b0;
      rst = 1'b0;
      m_reset();
      pin(7);
      @(posedge clk);
      #2;
      rst = 1'b1;
      clear_stats();
      for (int v = 10; v <= 15; v++) send(v, 1'b1);
      for (int v = 14; v >= 5; v--) send(v, 1'b1);
      pin(8);

      // Start mid-descent, then illegal 0 -> 15 wrap
      do_reset();
      send(15, 1'b1); send(14, 1'b1);
      pin(9);
      for (int v = 13; v >= 0; v--) send(v, 1'b1);
      pin(10);
      send(15, 1'b1);
      pin(11);

      // Randomized: mostly-clean wave, random holds and rare jumps
      do_reset();
      gpos = 0;
      gup  = 1'b1;
      for (int k = 0; k < 4000; k++) begin
         if ($urandom_range(0, 3) == 0) begin
            send(int'($urandom_range(0, MAXV)), 1'b0);
         end else begin
            if ($urandom_range(0, 149) == 0) gpos = int'($urandom_range(0, MAXV));
            else if (gup) begin
               if (gpos >= MAXV) begin gup = 1'b0; gpos = MAXV - 1; end
               else gpos++;
            end else begin
               if (gpos <= 0) begin gup = 1'b1; gpos = 1; end
               else gpos--;
            end
            send(gpos, 1'b1);
         end
      end
      pin(12);

`ifdef TRIANGLE_MONITOR_ERR_COUNT_EN
      // Three glitches, then a stuck stream to saturate the counter
      do_reset();
      for (int v = 0; v <= 9; v++) send(v, 1'b1);
      send(12, 1'b1);
      for (int v = 13; v <= 15; v++) send(v, 1'b1);
      for (int v = 14; v >= 10; v--) send(v, 1'b1);
      send(5, 1'b1);
      for (int v = 4; v >= 0; v--) send(v, 1'b1);
      for (int v = 1; v <= 3; v++) send(v, 1'b1);
      send(3, 1'b1);
      pin(13);
      for (int k = 0; k < 70000; k++) send(7, 1'b1);
      pin(14);
`endif

      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
